// File: rtl/npc_pkg.sv
// Shared NPC core definitions: default widths and load size encodings.
package npc_pkg;

    localparam int unsigned ADDR_WIDTH = 5;
    localparam int unsigned DATA_WIDTH = 32;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

endpackage

// File: rtl/wb_load_align.sv
// Load data formatter: selects byte/half/word by offset, extends by sign,
// and flags misaligned half/word accesses. Size 3 is handled as a word.
module wb_load_align
    import npc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = npc_pkg::DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [1:0]            size,
    input  logic [1:0]            off,
    input  logic                  sgn,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection and extension for the addressed byte or half.
    always_comb begin
        byte_sel = data[{off, 3'b000} +: 8];
        half_sel = data[{off[1], 4'b0000} +: 16];
        result   = data;
        misalign = 1'b0;
        case (size)
            SZ_B: begin
                result = sgn ? {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel}
                             : {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            end
            SZ_H: begin
                result   = sgn ? {{(DATA_WIDTH-16){half_sel[15]}}, half_sel}
                               : {{(DATA_WIDTH-16){1'b0}}, half_sel};
                misalign = off[0];
            end
            default: begin
                result   = data;
                misalign = (off != 2'd0);
            end
        endcase
    end

endmodule

// File: rtl/wb_unit.sv
// Writeback stage: LSU-over-EXU arbitration, registered register-file write
// port, per-register busy scoreboard and accepted-result counter.
module wb_unit
    import npc_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = npc_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = npc_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic [ADDR_WIDTH-1:0] exu_rd,
    input  logic [DATA_WIDTH-1:0] exu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    input  logic [1:0]            lsu_size,
    input  logic [1:0]            lsu_off,
    input  logic                  lsu_signed,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    input  logic [ADDR_WIDTH-1:0] q_raddr,
    output logic                  q_busy,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  err_misalign,
    output logic [31:0]           wb_count
);

    localparam int unsigned NREG = 2 ** ADDR_WIDTH;

    logic                  acc_lsu;
    logic                  acc_exu;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_mis;
    logic                  pend;
    logic [NREG-1:1]       busy_q;
    logic [NREG-1:0]       busy;

    wb_load_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_align (
        .data     (lsu_data),
        .size     (lsu_size),
        .off      (lsu_off),
        .sgn      (lsu_signed),
        .result   (load_data),
        .misalign (load_mis)
    );

    assign lsu_ready = !rst;
    assign exu_ready = !rst && !lsu_valid;
    assign acc_lsu   = lsu_valid && lsu_ready;
    assign acc_exu   = exu_valid && exu_ready;
    assign accept    = acc_lsu || acc_exu;

    // Select the accepted result (LSU has priority).
    always_comb begin
        sel_rd   = exu_rd;
        sel_data = exu_data;
        if (acc_lsu) begin
            sel_rd   = lsu_rd;
            sel_data = load_data;
        end
    end

    // Output register and counter; pend marks the edge that completes a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            wen          <= 1'b0;
            waddr        <= '0;
            wdata        <= '0;
            err_misalign <= 1'b0;
            pend         <= 1'b0;
            wb_count     <= '0;
        end else begin
            pend         <= accept;
            err_misalign <= acc_lsu && load_mis;
            wen          <= accept && (sel_rd != '0) && !(acc_lsu && load_mis);
            if (accept) begin
                waddr    <= sel_rd;
                wdata    <= sel_data;
                wb_count <= wb_count + 32'd1;
            end
        end
    end

    // Scoreboard: set on issue, clear when the write is presented; set wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            for (int unsigned i = 1; i < NREG; i++) begin
                if (iss_valid && iss_rd == ADDR_WIDTH'(i))
                    busy_q[i] <= 1'b1;
                else if (pend && waddr == ADDR_WIDTH'(i))
                    busy_q[i] <= 1'b0;
            end
        end
    end

    assign busy   = {busy_q, 1'b0};
    assign q_busy = busy[q_raddr];

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: load-format vector table, directed
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_wb_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        exu_valid, lsu_valid, lsu_signed, iss_valid;
    logic        exu_ready, lsu_ready, q_busy, wen, err_misalign;
    logic [4:0]  exu_rd, lsu_rd, iss_rd, q_raddr, waddr;
    logic [31:0] exu_data, lsu_data, wdata, wb_count;
    logic [1:0]  lsu_size, lsu_off;

    int n_cmp = 0;
    int n_bad = 0;

    // behavioural model state
    bit          busy_m [32];
    bit          pend_m;
    logic [4:0]  pend_rd;
    logic [31:0] cnt_m;

    always #5 clk = ~clk;

    wb_unit #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .lsu_size(lsu_size), .lsu_off(lsu_off), .lsu_signed(lsu_signed),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .q_raddr(q_raddr), .q_busy(q_busy),
        .wen(wen), .waddr(waddr), .wdata(wdata),
        .err_misalign(err_misalign), .wb_count(wb_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Load formatting from the arithmetic meaning of byte/half/word loads.
    function automatic void ref_load(input logic [31:0] d, input logic [1:0] sz,
                                     input logic [1:0] off, input bit sg,
                                     output logic [31:0] r, output bit mis);
        int unsigned o = off;
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (d >> (8 * o)) & 32'hFF;
            if (sg && v >= 128) v = v - 32'd256;
            mis = 0;
        end else if (sz == 2'd1) begin
            v = (d >> (16 * (o / 2))) & 32'hFFFF;
            if (sg && v >= 32768) v = v - 32'd65536;
            mis = (o % 2) != 0;
        end else begin
            v = d;
            mis = (o != 0);
        end
        r = v;
    endfunction

    task automatic idle_inputs();
        exu_valid = 0; lsu_valid = 0; iss_valid = 0;
        exu_rd = 0; lsu_rd = 0; iss_rd = 0; q_raddr = 0;
        exu_data = 0; lsu_data = 0; lsu_size = 2'd2; lsu_off = 0; lsu_signed = 0;
    endtask

    // One clock: check combinational outputs, cross the edge, check registers.
    task automatic cycle();
        bit          acc_l, acc_e, acc, mis, ewen;
        logic [4:0]  rd;
        logic [31:0] d;
        #2;
        chk("lsu_ready", {31'd0, lsu_ready}, {31'd0, !rst});
        chk("exu_ready", {31'd0, exu_ready}, {31'd0, (!rst && !lsu_valid)});
        chk("q_busy", {31'd0, q_busy}, {31'd0, busy_m[q_raddr]});
        acc_l = !rst && lsu_valid;
        acc_e = !rst && exu_valid && !lsu_valid;
        acc   = acc_l || acc_e;
        mis   = 0;
        if (acc_l) begin
            rd = lsu_rd;
            ref_load(lsu_data, lsu_size, lsu_off, lsu_signed, d, mis);
        end else begin
            rd = exu_rd;
            d  = exu_data;
        end
        ewen = acc && rd != 0 && !mis;
        @(posedge clk);
        if (rst) begin
            foreach (busy_m[i]) busy_m[i] = 0;
            pend_m = 0; cnt_m = 0; ewen = 0; mis = 0;
        end else begin
            if (pend_m) busy_m[pend_rd] = 0;
            if (iss_valid && iss_rd != 0) busy_m[iss_rd] = 1;
            pend_m = acc;
            if (acc) begin
                pend_rd = rd;
                cnt_m   = cnt_m + 1;
            end
        end
        #1;
        chk("wen", {31'd0, wen}, {31'd0, ewen});
        if (ewen) begin
            chk("waddr", {27'd0, waddr}, {27'd0, rd});
            chk("wdata", wdata, d);
        end
        if (rst) begin
            chk("waddr_rst", {27'd0, waddr}, 32'd0);
            chk("wdata_rst", wdata, 32'd0);
        end
        chk("err_misalign", {31'd0, err_misalign}, {31'd0, acc_l && mis});
        chk("wb_count", wb_count, cnt_m);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        cycle();
        cycle();
        rst = 0;
    endtask

    typedef struct {
        logic [31:0] data;
        logic [1:0]  size;
        logic [1:0]  off;
        bit          sg;
        logic [31:0] exp_wdata;
        bit          exp_wen;
        bit          exp_err;
    } load_vec_t;

    load_vec_t vecs [10];

    initial begin
        vecs[0] = '{32'h80FF7F01, 2'd0, 2'd2, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[1] = '{32'h80FF7F01, 2'd1, 2'd2, 1'b0, 32'h000080FF, 1'b1, 1'b0};
        vecs[2] = '{32'h80FF7F01, 2'd0, 2'd3, 1'b1, 32'hFFFFFF80, 1'b1, 1'b0};
        vecs[3] = '{32'h80FF7F01, 2'd0, 2'd3, 1'b0, 32'h00000080, 1'b1, 1'b0};
        vecs[4] = '{32'h80FF7F01, 2'd1, 2'd0, 1'b1, 32'h00007F01, 1'b1, 1'b0};
        vecs[5] = '{32'h80FF7F01, 2'd1, 2'd2, 1'b1, 32'hFFFF80FF, 1'b1, 1'b0};
        vecs[6] = '{32'h80FF7F01, 2'd2, 2'd0, 1'b1, 32'h80FF7F01, 1'b1, 1'b0};
        vecs[7] = '{32'h12345678, 2'd3, 2'd0, 1'b1, 32'h12345678, 1'b1, 1'b0};
        vecs[8] = '{32'h80FF7F01, 2'd1, 2'd1, 1'b1, 32'h0, 1'b0, 1'b1};
        vecs[9] = '{32'h80FF7F01, 2'd2, 2'd1, 1'b0, 32'h0, 1'b0, 1'b1};

        idle_inputs();
        rst = 1;
        foreach (busy_m[i]) busy_m[i] = 0;
        pend_m = 0; pend_rd = 0; cnt_m = 0;
        @(posedge clk); #1;
        do_reset();
        chk("reset_wen", {31'd0, wen}, 32'd0);
        chk("reset_count", wb_count, 32'd0);

        // Load-format table
        for (int i = 0; i < 10; i++) begin
            lsu_valid = 1; lsu_rd = 5'd9; lsu_data = vecs[i].data;
            lsu_size = vecs[i].size; lsu_off = vecs[i].off; lsu_signed = vecs[i].sg;
            cycle();
            lsu_valid = 0;
            chk($sformatf("vec%0d_wen", i), {31'd0, wen}, {31'd0, vecs[i].exp_wen});
            chk($sformatf("vec%0d_err", i), {31'd0, err_misalign}, {31'd0, vecs[i].exp_err});
            if (vecs[i].exp_wen) chk($sformatf("vec%0d_wdata", i), wdata, vecs[i].exp_wdata);
            cycle();
            chk($sformatf("vec%0d_err_off", i), {31'd0, err_misalign}, 32'd0);
        end

        // EXU only
        do_reset();
        exu_valid = 1; exu_rd = 5'd5; exu_data = 32'hDEADBEEF;
        cycle();
        exu_valid = 0;
        chk("exu_wen", {31'd0, wen}, 32'd1);
        chk("exu_waddr", {27'd0, waddr}, 32'd5);
        chk("exu_wdata", wdata, 32'hDEADBEEF);
        cycle();
        chk("exu_wen_n2", {31'd0, wen}, 32'd0);
        chk("exu_count", wb_count, 32'd1);

        // Contention: LSU first, EXU next cycle, no bubble
        lsu_valid = 1; lsu_rd = 5'd3; lsu_data = 32'h11111111; lsu_size = 2'd2; lsu_off = 0;
        exu_valid = 1; exu_rd = 5'd4; exu_data = 32'h44444444;
        #1;
        chk("cont_exu_ready", {31'd0, exu_ready}, 32'd0);
        cycle();
        lsu_valid = 0;
        chk("cont_first", {27'd0, waddr}, 32'd3);
        cycle();
        exu_valid = 0;
        chk("cont_second_wen", {31'd0, wen}, 32'd1);
        chk("cont_second", {27'd0, waddr}, 32'd4);
        cycle();

        // x0 write
        exu_valid = 1; exu_rd = 5'd0; exu_data = 32'hCAFE0000;
        cycle();
        exu_valid = 0;
        chk("x0_wen", {31'd0, wen}, 32'd0);
        chk("x0_count", wb_count, 32'd4);
        cycle();

        // Scoreboard set / clear
        iss_valid = 1; iss_rd = 5'd7;
        cycle();
        iss_valid = 0; q_raddr = 5'd7;
        #1 chk("sb_set", {31'd0, q_busy}, 32'd1);
        exu_valid = 1; exu_rd = 5'd7; exu_data = 32'h77;
        cycle();
        exu_valid = 0;
        chk("sb_busy_during_write", {31'd0, q_busy}, 32'd1);
        cycle();
        chk("sb_cleared", {31'd0, q_busy}, 32'd0);
        // same-edge set and clear: set wins
        iss_valid = 1;
        cycle();
        iss_valid = 0; exu_valid = 1;
        cycle();
        exu_valid = 0; iss_valid = 1;
        cycle();
        iss_valid = 0;
        chk("sb_set_wins", {31'd0, q_busy}, 32'd1);
        cycle();
        chk("sb_set_wins_hold", {31'd0, q_busy}, 32'd1);

        // Reset mid-operation
        lsu_valid = 1; lsu_rd = 5'd6; lsu_data = 32'h0; lsu_size = 2'd2; lsu_off = 2'd1;
        cycle();
        lsu_valid = 1; rst = 1; lsu_off = 0;
        cycle();
        chk("rst_mid_wen", {31'd0, wen}, 32'd0);
        chk("rst_mid_err", {31'd0, err_misalign}, 32'd0);
        lsu_valid = 0; rst = 0;
        cycle();
        chk("rst_mid_wen2", {31'd0, wen}, 32'd0);
        chk("rst_mid_count", wb_count, 32'd0);
        q_raddr = 5'd7;
        #1 chk("rst_mid_busy", {31'd0, q_busy}, 32'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            rst        = ($urandom_range(0, 39) == 0);
            exu_valid  = $urandom_range(0, 1);
            lsu_valid  = ($urandom_range(0, 2) == 0);
            exu_rd     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            lsu_rd     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            exu_data   = $urandom;
            lsu_data   = $urandom;
            lsu_size   = 2'($urandom);
            lsu_off    = 2'($urandom);
            lsu_signed = $urandom_range(0, 1);
            iss_valid  = $urandom_range(0, 1);
            iss_rd     = 5'($urandom);
            q_raddr    = 5'($urandom_range(0, 7));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
